// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with single-cycle hits and a one-word
// refill from memory on a miss.
module icache_direct #(
  parameter int NSETS = 16,
  parameter int TAGW  = 30 - $clog2(NSETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int IDXW = $clog2(NSETS);

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q, state_d;
  logic [NSETS-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [NSETS];
  logic [31:0]       data_q [NSETS];
  logic [29:0]       maddr_q, maddr_d;

  logic [IDXW-1:0]   req_idx, fill_idx;
  logic [TAGW-1:0]   req_tag, fill_tag;
  logic              lookup_hit;
  logic              fill_we;
  logic              unused_byte_offset;

  assign req_idx    = imemaddr[IDXW+1:2];
  assign req_tag    = imemaddr[IDXW+2 +: TAGW];
  assign fill_idx   = maddr_q[IDXW-1:0];
  assign fill_tag   = maddr_q[IDXW +: TAGW];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Fetches are word aligned; the byte offset never takes part in a lookup.
  assign unused_byte_offset = ^imemaddr[1:0];

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    maddr_d = maddr_q;
    ihit    = 1'b0;
    iREN    = 1'b0;
    fill_we = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = imemREN && lookup_hit;
        if (imemREN && !lookup_hit) begin
          maddr_d = imemaddr[31:2];
          state_d = FILL;
        end
      end
      FILL: begin
        iREN = 1'b1;
        if (!iwait) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imemload = ihit ? data_q[req_idx] : 32'h0;
  assign iaddr    = {maddr_q, 2'b00};

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      maddr_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are not reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge CLK) begin
    if (fill_we && !nRST) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized fetch
// traffic compared against a frame-by-frame cache model and a word memory model.
module tb_icache_direct;
  localparam int NSETS = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int vectors = 0;
  int errors  = 0;

  // Reference model: which word address each frame holds, plus backing memory.
  bit          m_valid [NSETS];
  logic [29:0] m_line  [NSETS];
  logic [31:0] mem [logic [29:0]];

  icache_direct #(.NSETS(NSETS)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    nRST = 1'b1;
    imemREN = 1'($urandom);
    imemaddr = $urandom;
    iwait = 1'b1;
    iload = $urandom;
    for (int i = 0; i < cycles; i++) step();
    nRST = 1'b0;
    for (int i = 0; i < NSETS; i++) m_valid[i] = 0;
  endtask

  // One fetch of addr; on a miss the memory answers after 'waits' busy cycles while
  // the fetch port is driven with alt_addr/alt_ren.
  task automatic do_fetch(input logic [31:0] addr, input int waits,
                          input logic [31:0] alt_addr, input logic alt_ren);
    logic [29:0] w;
    int          idx;
    logic        hit;
    logic [31:0] exp_d;
    w     = addr[31:2];
    idx   = int'(w % NSETS);
    hit   = m_valid[idx] && (m_line[idx] == w);
    exp_d = hit ? mem_rd(w) : 32'h0;
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = $urandom;
    @(negedge CLK);
    vectors++;
    if (ihit !== hit)
      begin errors++; $display("FAIL lookup_ihit addr=%h got=%b exp=%b", addr, ihit, hit); end
    vectors++;
    if (imemload !== exp_d)
      begin errors++; $display("FAIL lookup_data addr=%h got=%h exp=%h", addr, imemload, exp_d); end
    vectors++;
    if (iREN !== 1'b0)
      begin errors++; $display("FAIL lookup_iren addr=%h got=%b exp=0", addr, iREN); end
    step();
    if (!hit) begin
      for (int c = 0; c <= waits; c++) begin
        imemREN  = alt_ren;
        imemaddr = alt_addr;
        iwait    = (c < waits);
        iload    = (c < waits) ? $urandom : mem_rd(w);
        @(negedge CLK);
        vectors++;
        if (iREN !== 1'b1)
          begin errors++; $display("FAIL fill_iren addr=%h cyc=%0d got=%b exp=1", addr, c, iREN); end
        vectors++;
        if (iaddr !== {w, 2'b00})
          begin errors++; $display("FAIL fill_iaddr cyc=%0d got=%h exp=%h", c, iaddr, {w, 2'b00}); end
        vectors++;
        if (ihit !== 1'b0 || imemload !== 32'h0)
          begin errors++; $display("FAIL fill_nohit cyc=%0d got=%b/%h exp=0/0", c, ihit, imemload); end
        step();
      end
      m_valid[idx] = 1;
      m_line[idx]  = w;
    end
  endtask

  task automatic idle_cycle(input logic [31:0] addr);
    imemREN  = 1'b0;
    imemaddr = addr;
    iwait    = 1'($urandom);
    iload    = $urandom;
    @(negedge CLK);
    vectors++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0)
      begin errors++; $display("FAIL idle addr=%h got ihit=%b load=%h iren=%b exp 0/0/0", addr, ihit, imemload, iREN); end
    step();
  endtask

  task automatic test_reset();
    apply_reset(2);
    imemREN = 1'b0;
    imemaddr = 32'h40;
    @(negedge CLK);
    vectors++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0)
      begin errors++; $display("FAIL reset_outputs got %b %h %b %h exp 0 0 0 0", ihit, imemload, iREN, iaddr); end
    step();
  endtask

  task automatic test_cold_miss();
    mem[30'h10] = 32'h8C220004;
    do_fetch(32'h40, 3, 32'h40, 1'b1);
    do_fetch(32'h40, 0, 32'h40, 1'b1);
  endtask

  task automatic test_warm_hit();
    idle_cycle(32'h40);
    do_fetch(32'h40, 0, 32'h40, 1'b1);
  endtask

  task automatic test_conflict();
    mem[30'h20] = 32'h3C01FFFF;
    do_fetch(32'h80, 1, 32'h80, 1'b1);
    do_fetch(32'h80, 0, 32'h80, 1'b1);
    do_fetch(32'h40, 2, 32'h40, 1'b1);
    do_fetch(32'h3C, 1, 32'h3C, 1'b1);
    do_fetch(32'h7C, 0, 32'h7C, 1'b1);
    do_fetch(32'h3C, 0, 32'h3C, 1'b1);
  endtask

  task automatic test_addr_change();
    do_fetch(32'h104, 0, 32'h104, 1'b1);
    do_fetch(32'h100, 2, 32'h104, 1'b1);
    do_fetch(32'h104, 1, 32'h104, 1'b1);
    do_fetch(32'h100, 0, 32'h100, 1'b1);
    do_fetch(32'h104, 0, 32'h104, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    do_fetch(32'h40, 0, 32'h40, 1'b1);
    imemREN  = 1'b1;
    imemaddr = 32'h84;
    iwait    = 1'b1;
    if (m_valid[1] && m_line[1] == 30'h21) do_fetch(32'h04, 0, 32'h04, 1'b1);
    imemaddr = 32'h84;
    step();
    nRST  = 1'b1;
    iwait = 1'b1;
    @(negedge CLK);
    vectors++;
    if (iREN !== 1'b1)
      begin errors++; $display("FAIL rst_fill_iren got=%b exp=1", iREN); end
    step();
    nRST = 1'b0;
    for (int i = 0; i < NSETS; i++) m_valid[i] = 0;
    imemREN = 1'b0;
    iwait   = 1'b0;
    @(negedge CLK);
    vectors++;
    if (iREN !== 1'b0 || iaddr !== 32'h0)
      begin errors++; $display("FAIL rst_fill_idle got iren=%b iaddr=%h exp 0/0", iREN, iaddr); end
    step();
    do_fetch(32'h40, 0, 32'h40, 1'b1);
  endtask

  task automatic test_zero_wait();
    for (int pass = 0; pass < 2; pass++)
      for (int a = 0; a < 3; a++) begin
        do_fetch(32'(a * 4), 0, 32'(a * 4), 1'b1);
        if (pass == 0) do_fetch(32'(a * 4), 0, 32'(a * 4), 1'b1);
      end
  endtask

  task automatic test_random();
    logic [31:0] a, alt;
    for (int i = 0; i < 120; i++) begin
      a   = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom)};
      alt = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) idle_cycle(a);
      else do_fetch(a, $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? alt : a, 1'($urandom));
    end
  endtask

  initial begin
    nRST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    #1;
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_addr_change();
    test_reset_mid_fill();
    apply_reset(1);
    test_zero_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller. It answers fetch requests (`imemREN`/`imemaddr`) with a single-cycle combinational hit (`ihit`/`imemload`). On a miss it runs a one-word refill from memory (`iREN`/`iaddr`/`iwait`/`iload`). The datapath advances the PC only on `ihit`, so this block sets the fetch-stage stall behaviour.

## Interface

Parameters:
- `NSETS`, default 16: number of frames; a power of two, at least 2. `IDXW = log2(NSETS)`.
- `TAGW`, default `30 - IDXW`: tag width.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  reset, synchronous and active-high. A value of 1 at a rising edge resets the block. The name follows codebase convention; the polarity is active-high.
- `imemREN`  in  1  fetch request from datapath.
- `imemaddr`  in  32  fetch byte address. Bits [1:0] are ignored, index = [IDXW+1:2], tag = [31:IDXW+2].
- `ihit`  out  1  fetch data valid this cycle.
- `imemload`  out  32  instruction word; equals the frame data when `ihit`=1, otherwise 0.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address, with [1:0] forced to 00.
- `iwait`  in  1  memory busy; `iload` is valid in the first cycle `iREN`=1 and `iwait`=0.
- `iload`  in  32  memory read data.

## Operation

Storage:
- Per frame: `valid` (1 bit), `tag` (`TAGW` bits), `data` (32 bits).
- Registered miss address `maddr[31:2]`.

States:
- **IDLE**
  - `ihit = imemREN & valid[idx] & (tag[idx] == addr tag)`; `iREN` = 0.
  - If `imemREN` is high and the lookup misses, latch `maddr <= imemaddr[31:2]` and go to FILL.
- **FILL**
  - `iREN` = 1, `iaddr = {maddr, 2'b00}`, `ihit` = 0. `iaddr` is stable for the whole state.
  - On a cycle with `iwait` = 0: write `data[maddr idx] <= iload`, `tag <= maddr tag`, `valid <= 1`, then go to IDLE.
- Transitions: IDLE to FILL on a miss; FILL to IDLE on `iwait` = 0. There are no other transitions.

Boundary rules:
- `imemREN` deasserts or `imemaddr` changes during FILL: the refill still completes to `maddr`, with no abort, because the memory transaction is already in flight. On return to IDLE the new address is looked up normally.
- A refill evicts the previous occupant of its frame unconditionally; there is no dirty state.
- `imemREN` = 0 in IDLE: `ihit` = 0, `imemload` = 0, and state is unchanged.
- Index 0 and index `NSETS-1` behave identically. Addresses differing only in the tag alias to the same frame and evict each other.
- Reset, including reset during FILL: all `valid` cleared, state goes to IDLE, `maddr` cleared. Any in-flight memory response is ignored.

## Timing

- Reset values, from the first cycle after reset: `ihit` = 0, `imemload` = 0, `iREN` = 0, `iaddr` = 0, all frames invalid.
- Hit latency: 0 cycles. `ihit` and `imemload` are combinational from `imemaddr`/`imemREN` in the same cycle.
- Miss latency: the miss is detected in cycle 0 (IDLE) and `iREN` rises in cycle 1. If memory completes after W wait cycles, the frame is written at the end of cycle 1+W, and `ihit` for the same address is asserted in cycle 2+W. Minimum miss-to-hit time is 2 cycles (W = 0).
- `iREN` is a registered-state decode with no combinational path from `imemaddr`. `iaddr` depends only on `maddr`.
- Back-to-back misses: FILL returns to IDLE for exactly one cycle before a new FILL. That IDLE cycle is when the next lookup is performed.

## Test plan

1. **Reset and cold miss.** Reset for 2 cycles, then `imemREN`=1, `imemaddr`=0x00000040, memory `iwait`=1 for 3 cycles, `iload`=0x8C220004. Required: `iREN`=1 with `iaddr`=0x40 for 4 cycles, then `ihit`=1 with `imemload`=0x8C220004 in the following cycle.
2. **Warm hit.** Re-request 0x40 later with `iwait` held at 1. Required: `ihit`=1 in the same cycle, `iREN` stays 0.
3. **Conflict eviction.** With `NSETS`=16, fill 0x40, then fetch 0x80 (also index 0) with data 0x3C01FFFF. Required: miss and refill of 0x80. A subsequent fetch of 0x40 misses again.
4. **Address change mid-fill.** Miss on 0x100, then switch `imemaddr` to 0x104 while `iwait`=1. Required: `iaddr` stays 0x100 and frame 0 gets 0x100's data. In the IDLE cycle after the fill, 0x104 misses and starts its own FILL.
5. **Reset mid-fill.** Assert `nRST`=1 during FILL with `iwait`=1. Required: next cycle `iREN`=0 and state IDLE. A previously cached 0x40 now misses.
6. **Zero-wait memory.** `iwait`=0 permanently; sequential fetches 0x0, 0x4, 0x8. Required: each first access gives `ihit` exactly 2 cycles after request. A second pass over the same addresses hits with 0 stall.
